// File: rtl/mips_pkg.sv
// Shared MIPS constants and the fetch-buffer entry layout.
package mips_pkg;

  localparam int unsigned XLEN = 32;

  // Opcodes (ins[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (ins[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_OR  = 6'h25;

  // Program entry point
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'd128;

  // One fetch-buffer entry as seen by decode
  typedef struct packed {
    logic [XLEN-1:0] ins;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcp4;
  } fetch_entry_t;

  localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Fetch unit bus: instruction memory, decode handshake and EX redirect.
interface fetch_pc_unit_if;

  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ins;
  logic [31:0] out_pc;
  logic [31:0] out_pcp4;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  // Fetch unit side
  modport master (
    output imem_addr,
    input  imem_rdata,
    output out_valid,
    input  out_ready,
    output out_ins,
    output out_pc,
    output out_pcp4,
    input  redirect_valid,
    input  redirect_pc
  );

  // Memory / decode / EX side
  modport slave (
    input  imem_addr,
    output imem_rdata,
    input  out_valid,
    output out_ready,
    input  out_ins,
    input  out_pc,
    input  out_pcp4,
    output redirect_valid,
    output redirect_pc
  );

endinterface

// File: rtl/fetch_pc_unit_fifo.sv
// Small fetch buffer with flush and a registered head entry.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 96
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push_i,
  input  logic                           pop_i,
  input  logic                           flush_i,
  input  logic [WIDTH-1:0]               wdata_i,
  output logic [$clog2(DEPTH):0]         count_o,
  output logic                           valid_o,
  output logic [WIDTH-1:0]               head_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             valid_q, valid_d;
  logic             do_pop, do_push;

  // Next-state for storage, pointers, count and the head register
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    valid_d  = valid_q;
    do_pop   = pop_i & (count_q != '0);
    do_push  = push_i & ((count_q < CNT_W'(DEPTH)) | do_pop);

    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      head_d   = '0;
      valid_d  = 1'b0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata_i;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      valid_d = (count_d != '0);
      // New head: bypass the write when it lands at the new read slot
      if (count_d == '0) begin
        head_d = '0;
      end else if (do_push && (rd_ptr_d == wr_ptr_q)) begin
        head_d = wdata_i;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
    end
  end

  assign count_o = count_q;
  assign valid_o = valid_q;
  assign head_o  = head_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch front end: PC register, next-PC selection and fetch buffer feeding decode.
// Optional build macro FETCH_JUMP_PREDECODE_EN: follow j targets at fetch time.
module fetch_pc_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  fetch_pc_unit_if.master bus
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  pc_plus4;
  logic [XLEN-1:0]  next_pc;
  logic             pop, push;
  logic [CNT_W-1:0] count;
  logic             head_valid;
  fetch_entry_t     wr_entry;
  fetch_entry_t     head;

  assign bus.imem_addr = pc_q;
  assign pc_plus4      = pc_q + 32'd4;

  // Handshake: redirect voids the pop and blocks the push
  always_comb begin
    pop  = bus.out_valid & bus.out_ready & ~bus.redirect_valid;
    push = ~bus.redirect_valid & ((count < CNT_W'(FIFO_DEPTH)) | pop);
  end

  // Entry written on push
  always_comb begin
    wr_entry      = '0;
    wr_entry.ins  = bus.imem_rdata;
    wr_entry.pc   = pc_q;
    wr_entry.pcp4 = pc_plus4;
  end

  // Address following the instruction being pushed
  always_comb begin
    next_pc = pc_plus4;
`ifdef FETCH_JUMP_PREDECODE_EN
    if (bus.imem_rdata[31:26] == OP_J) begin
      next_pc = {pc_plus4[31:28], bus.imem_rdata[25:0], 2'b00};
    end
`endif
  end

  // PC next-state: redirect over push over hold
  always_comb begin
    pc_d = pc_q;
    if (bus.redirect_valid) begin
      pc_d = {bus.redirect_pc[31:2], 2'b00};
    end else if (push) begin
      pc_d = next_pc;
    end
  end

  // PC register
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FETCH_ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (bus.redirect_valid),
    .wdata_i (wr_entry),
    .count_o (count),
    .valid_o (head_valid),
    .head_o  (head)
  );

  assign bus.out_valid = head_valid;
  assign bus.out_ins   = head.ins;
  assign bus.out_pc    = head.pc;
  assign bus.out_pcp4  = head.pcp4;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit.
module tb_fetch_pc_unit;

  logic clk;
  logic rst;
  logic imem_ovr_en;
  logic [31:0] imem_ovr;
  int n_cmp;
  int n_fail;

  fetch_pc_unit_if bus ();

  fetch_pc_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: addi with the low address bits as immediate
  function automatic logic [31:0] ins_of(input logic [31:0] a);
    return 32'h2000_0000 | {16'h0000, a[15:0]};
  endfunction

  assign bus.imem_rdata = imem_ovr_en ? imem_ovr : ins_of(bus.imem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_pc"}, bus.out_pc, pc);
    chk({tag, "_pcp4"}, bus.out_pcp4, pc + 32'd4);
    chk({tag, "_ins"}, bus.out_ins, ins_of(pc));
  endtask

  initial begin
    logic [31:0] jexp;
    n_cmp = 0;
    n_fail = 0;
    imem_ovr_en = 1'b0;
    imem_ovr = 32'h0;
    rst = 1'b1;
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;

    // 1. reset state, then streaming with decode always ready
    tick();
    tick();
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_ins", bus.out_ins, 32'h0);
    chk("rst_pc", bus.out_pc, 32'h0);
    chk("rst_pcp4", bus.out_pcp4, 32'h0);
    chk("rst_addr", bus.imem_addr, 32'd128);
    rst = 1'b0;
    chk("rel_addr", bus.imem_addr, 32'd128);
    tick();
    chk_head("s1_a", 32'd128);
    chk("s1_a_addr", bus.imem_addr, 32'd132);
    tick();
    chk_head("s1_b", 32'd132);
    chk("s1_b_addr", bus.imem_addr, 32'd136);

    // 2. decode stalled from reset: two pushes then PC stalls
    rst = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk_head("s2_a", 32'd128);
    chk("s2_a_addr", bus.imem_addr, 32'd132);
    tick();
    chk("s2_b_addr", bus.imem_addr, 32'd136);
    chk("s2_b_pc", bus.out_pc, 32'd128);
    tick();
    chk("s2_c_addr", bus.imem_addr, 32'd136);
    chk("s2_c_pc", bus.out_pc, 32'd128);
    tick();
    chk("s2_d_addr", bus.imem_addr, 32'd136);
    bus.out_ready = 1'b1;
    tick();
    chk_head("s2_e", 32'd132);
    chk("s2_e_addr", bus.imem_addr, 32'd140);
    tick();
    chk_head("s2_f", 32'd136);
    chk("s2_f_addr", bus.imem_addr, 32'd144);

    // 3. redirect while full
    bus.out_ready = 1'b0;
    tick();
    chk("s3_full_addr", bus.imem_addr, 32'd144);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'd200;
    tick();
    chk("s3_valid", 32'(bus.out_valid), 32'd0);
    chk("s3_addr", bus.imem_addr, 32'd200);
    bus.redirect_valid = 1'b0;
    tick();
    chk_head("s3_head", 32'd200);

    // 4. misaligned redirect and PC wrap at the top of memory
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_00CB;
    tick();
    chk("s4_align", bus.imem_addr, 32'h0000_00C8);
    chk("s4_valid", 32'(bus.out_valid), 32'd0);
    bus.redirect_pc = 32'hFFFF_FFFC;
    bus.out_ready = 1'b1;
    tick();
    chk("s4_top_addr", bus.imem_addr, 32'hFFFF_FFFC);
    bus.redirect_valid = 1'b0;
    tick();
    chk("s4_top_pc", bus.out_pc, 32'hFFFF_FFFC);
    chk("s4_top_pcp4", bus.out_pcp4, 32'h0);
    chk("s4_wrap_addr", bus.imem_addr, 32'h0);
    tick();
    chk_head("s4_zero", 32'h0);
    chk("s4_four_addr", bus.imem_addr, 32'h4);

    // 5. redirect in the same cycle as a pop
    chk("s5_pre_valid", 32'(bus.out_valid), 32'd1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'd300;
    tick();
    chk("s5_valid", 32'(bus.out_valid), 32'd0);
    chk("s5_addr", bus.imem_addr, 32'd300);
    bus.redirect_valid = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    chk_head("s5_a", 32'd300);
    tick();
    chk("s5_b_pc", bus.out_pc, 32'd300);
    chk("s5_b_addr", bus.imem_addr, 32'd308);
    bus.out_ready = 1'b1;
    tick();
    chk_head("s5_c", 32'd304);

    // 6. reset beats a simultaneous redirect; then a j at the entry point
    rst = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'd400;
    tick();
    chk("s6_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("s6_rst_addr", bus.imem_addr, 32'd128);
    rst = 1'b0;
    bus.redirect_valid = 1'b0;
    imem_ovr_en = 1'b1;
    imem_ovr = 32'h0800_0040;
    tick();
    imem_ovr_en = 1'b0;
`ifdef FETCH_JUMP_PREDECODE_EN
    jexp = 32'h0000_0100;
`else
    jexp = 32'd132;
`endif
    chk("s6_j_addr", bus.imem_addr, jexp);
    chk("s6_j_ins", bus.out_ins, 32'h0800_0040);
    chk("s6_j_pc", bus.out_pc, 32'd128);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
